// File: rtl/muldiv_iterative_unit_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
interface muldiv_iterative_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic            req_signa;
  logic            req_signb;
  logic            req_div_sign;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic [4:0]      req_rd;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic [4:0]      resp_rd;

  modport master (
    output req_valid, req_op, req_signa, req_signb, req_div_sign, req_a, req_b, req_rd,
    output resp_ready,
    input  req_ready, resp_valid, resp_result, resp_rd
  );

  modport slave (
    input  req_valid, req_op, req_signa, req_signb, req_div_sign, req_a, req_b, req_rd,
    input  resp_ready,
    output req_ready, resp_valid, resp_result, resp_rd
  );
endinterface

// File: rtl/muldiv_iterative_unit.sv
// Iterative RISC-V M-extension unit: shift-add multiply, restoring divide, BITS_PER_CYCLE bits/iteration.
// Optional last-division result cache enabled by defining MULDIV_PAIR_CACHE_EN.
module muldiv_iterative_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  output logic                   busy,
  muldiv_iterative_unit_if.slave bus
);
  localparam int unsigned     ITERS = XLEN / BITS_PER_CYCLE;
  localparam int unsigned     CW    = $clog2(ITERS + 1);
  localparam logic [XLEN-1:0] SMIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    WB_MUL  = 3'd3,
    WB_MULH = 3'd4,
    WB_DIV  = 3'd5,
    WB_REM  = 3'd6
  } wb_op_e;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [1:0] {K_MUL, K_MULH, K_DIV, K_REM} kind_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  kind_e             kind_q, kind_d;
  logic [4:0]        rd_q, rd_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN:0]     hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     it_hi;
  logic [XLEN-1:0]   it_lo;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic              spec_hit;
  logic [XLEN-1:0]   spec_q, spec_r;

`ifdef MULDIV_PAIR_CACHE_EN
  logic              cv_q;
  logic [XLEN-1:0]   ca_q, cb_q, cq_q, cr_q;
  logic              cs_q;
  logic [XLEN-1:0]   pa_q, pa_d, pb_q, pb_d;
  logic              ps_q, ps_d;
  logic              cwr;
  logic [XLEN-1:0]   cw_a, cw_b, cw_q, cw_r;
  logic              cw_s;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    rd_d     = rd_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    result_d = result_q;
`ifdef MULDIV_PAIR_CACHE_EN
    pa_d = pa_q;
    pb_d = pb_q;
    ps_d = ps_q;
    cwr  = 1'b0;
    cw_a = pa_q;
    cw_b = pb_q;
    cw_s = ps_q;
    cw_q = '0;
    cw_r = '0;
`endif

    // Multiply: {hi,lo} is the running product, shifted right as multiplier bits are consumed.
    // Divide: {hi,lo} is partial remainder and dividend/quotient, shifted left.
    it_hi = hi_q;
    it_lo = lo_q;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (kind_q == K_MUL || kind_q == K_MULH) begin
        if (it_lo[0]) it_hi = it_hi + {1'b0, opb_q};
        it_lo = {it_hi[0], it_lo[XLEN-1:1]};
        it_hi = {1'b0, it_hi[XLEN:1]};
      end else begin
        it_hi = {it_hi[XLEN-1:0], it_lo[XLEN-1]};
        it_lo = {it_lo[XLEN-2:0], 1'b0};
        if (it_hi >= {1'b0, opb_q}) begin
          it_hi    = it_hi - {1'b0, opb_q};
          it_lo[0] = 1'b1;
        end
      end
    end

    prod = {it_hi[XLEN-1:0], it_lo};
    if (qneg_q) prod = -prod;
    quo = qneg_q ? -it_lo : it_lo;
    rem = rneg_q ? -it_hi[XLEN-1:0] : it_hi[XLEN-1:0];

    neg_a = 1'b0;
    neg_b = 1'b0;
    case (bus.req_op)
      WB_MULH: begin
        neg_a = bus.req_signa & bus.req_a[XLEN-1];
        neg_b = bus.req_signa & bus.req_signb & bus.req_b[XLEN-1];
      end
      WB_DIV, WB_REM: begin
        neg_a = bus.req_div_sign & bus.req_a[XLEN-1];
        neg_b = bus.req_div_sign & bus.req_b[XLEN-1];
      end
      default: ;
    endcase
    mag_a = neg_a ? -bus.req_a : bus.req_a;
    mag_b = neg_b ? -bus.req_b : bus.req_b;

    spec_hit = 1'b0;
    spec_q   = '1;
    spec_r   = bus.req_a;
    if (bus.req_b == '0) begin
      spec_hit = 1'b1;
    end else if (bus.req_div_sign && bus.req_a == SMIN && bus.req_b == '1) begin
      spec_hit = 1'b1;
      spec_q   = bus.req_a;
      spec_r   = '0;
    end
`ifdef MULDIV_PAIR_CACHE_EN
    else if (cv_q && bus.req_a == ca_q && bus.req_b == cb_q && bus.req_div_sign == cs_q) begin
      spec_hit = 1'b1;
      spec_q   = cq_q;
      spec_r   = cr_q;
    end
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          rd_d    = bus.req_rd;
          hi_d    = '0;
          lo_d    = mag_a;
          opb_d   = mag_b;
          qneg_d  = neg_a ^ neg_b;
          rneg_d  = neg_a;
          cnt_d   = CW'(ITERS);
          state_d = S_BUSY;
          case (bus.req_op)
            WB_MUL:  kind_d = K_MUL;
            WB_MULH: kind_d = K_MULH;
            WB_DIV, WB_REM: begin
              kind_d = (bus.req_op == WB_DIV) ? K_DIV : K_REM;
`ifdef MULDIV_PAIR_CACHE_EN
              pa_d = bus.req_a;
              pb_d = bus.req_b;
              ps_d = bus.req_div_sign;
`endif
              if (spec_hit) begin
                state_d  = S_DONE;
                cnt_d    = '0;
                result_d = (bus.req_op == WB_DIV) ? spec_q : spec_r;
`ifdef MULDIV_PAIR_CACHE_EN
                cwr  = 1'b1;
                cw_a = bus.req_a;
                cw_b = bus.req_b;
                cw_s = bus.req_div_sign;
                cw_q = spec_q;
                cw_r = spec_r;
`endif
              end
            end
            default: begin
              state_d  = S_DONE;
              cnt_d    = '0;
              result_d = '0;
            end
          endcase
        end
      end
      S_BUSY: begin
        hi_d  = it_hi;
        lo_d  = it_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          case (kind_q)
            K_MUL:   result_d = prod[XLEN-1:0];
            K_MULH:  result_d = prod[2*XLEN-1:XLEN];
            K_DIV:   result_d = quo;
            default: result_d = rem;
          endcase
`ifdef MULDIV_PAIR_CACHE_EN
          if (kind_q == K_DIV || kind_q == K_REM) begin
            cwr  = 1'b1;
            cw_q = quo;
            cw_r = rem;
          end
`endif
        end
      end
      S_DONE: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush kills everything in flight, including a same-cycle accept and its cache fill.
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
`ifdef MULDIV_PAIR_CACHE_EN
      cwr = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      kind_q   <= K_MUL;
      rd_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
      rd_q     <= rd_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

`ifdef MULDIV_PAIR_CACHE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pa_q <= '0;
      pb_q <= '0;
      ps_q <= 1'b0;
      cv_q <= 1'b0;
      ca_q <= '0;
      cb_q <= '0;
      cs_q <= 1'b0;
      cq_q <= '0;
      cr_q <= '0;
    end else begin
      pa_q <= pa_d;
      pb_q <= pb_d;
      ps_q <= ps_d;
      if (cwr) begin
        cv_q <= 1'b1;
        ca_q <= cw_a;
        cb_q <= cw_b;
        cs_q <= cw_s;
        cq_q <= cw_q;
        cr_q <= cw_r;
      end
    end
  end
`endif

  assign bus.req_ready   = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign bus.resp_valid  = (state_q == S_DONE);
  assign bus.resp_result = result_q;
  assign bus.resp_rd     = rd_q;
endmodule

// File: tb/tb_muldiv_iterative_unit.sv
// Bench for muldiv_iterative_unit: directed vector table, flush/reset/backpressure sequences,
// and randomized ops against an arithmetic reference model (cache-aware when MULDIV_PAIR_CACHE_EN).
module tb_muldiv_iterative_unit;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NL   = 33;
`ifdef MULDIV_PAIR_CACHE_EN
  localparam int unsigned CL       = 1;
  localparam bit          CACHE_ON = 1'b1;
`else
  localparam int unsigned CL       = 33;
  localparam bit          CACHE_ON = 1'b0;
`endif
  localparam logic [31:0] SMIN = 32'h8000_0000;
  localparam int          NV   = 20;

  typedef struct {
    logic [2:0]  op;
    bit          sa;
    bit          sb;
    bit          ds;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int unsigned lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic busy;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  bit          mc_v = 1'b0;
  logic [31:0] mc_a = '0;
  logic [31:0] mc_b = '0;
  bit          mc_s = 1'b0;

  muldiv_iterative_unit_if #(.XLEN(XLEN)) bus ();

  muldiv_iterative_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input bit sa, input bit sb,
                                          input bit ds, input logic [31:0] a, input logic [31:0] b);
    longint      av, bv;
    logic [63:0] p;
    int          ia, ib;
    ref_res = '0;
    ia = a;
    ib = b;
    case (op)
      3'd3: begin
        p = {32'b0, a} * {32'b0, b};
        ref_res = p[31:0];
      end
      3'd4: begin
        av = sa ? longint'(ia) : longint'({32'b0, a});
        bv = (sa && sb) ? longint'(ib) : longint'({32'b0, b});
        p = av * bv;
        ref_res = p[63:32];
      end
      3'd5, 3'd6: begin
        if (b == 0)                          ref_res = (op == 3'd5) ? '1 : a;
        else if (ds && a == SMIN && b == '1) ref_res = (op == 3'd5) ? a : '0;
        else if (ds)                         ref_res = (op == 3'd5) ? 32'(ia / ib) : 32'(ia % ib);
        else                                 ref_res = (op == 3'd5) ? a / b : a % b;
      end
      default: ref_res = '0;
    endcase
  endfunction

  function automatic int unsigned ref_lat(input logic [2:0] op, input bit ds,
                                          input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd3 || op > 3'd6) return 1;
    if (op >= 3'd5) begin
      if (b == 0) return 1;
      if (ds && a == SMIN && b == '1) return 1;
      if (CACHE_ON && mc_v && mc_a == a && mc_b == b && mc_s == ds) return 1;
    end
    return NL;
  endfunction

  task automatic issue(input logic [2:0] op, input bit sa, input bit sb, input bit ds,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int unsigned n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.req_op       = op;
    bus.req_signa    = sa;
    bus.req_signb    = sb;
    bus.req_div_sign = ds;
    bus.req_a        = a;
    bus.req_b        = b;
    bus.req_rd       = rd;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int unsigned lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 100);
  endtask

  task automatic run_op(input logic [2:0] op, input bit sa, input bit sb, input bit ds,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int unsigned elat, input string nm);
    int unsigned lat;
    issue(op, sa, sb, ds, a, b, rd);
    wait_resp(lat);
    chk({nm, ".lat"}, 64'(lat), 64'(elat));
    chk({nm, ".res"}, 64'(bus.resp_result), 64'(exp));
    chk({nm, ".rd"},  64'(bus.resp_rd), 64'(rd));
    if (op == 3'd5 || op == 3'd6) begin
      mc_v = 1'b1;
      mc_a = a;
      mc_b = b;
      mc_s = ds;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vec_t        tbl [NV];
    int unsigned lat, elat, mode;
    logic [2:0]  op;
    bit          sa, sb, ds, pds, seen;
    logic [31:0] a, b, pa, pb, exp;

    reset            = 1'b1;
    flush            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_op       = '0;
    bus.req_signa    = 1'b0;
    bus.req_signb    = 1'b0;
    bus.req_div_sign = 1'b0;
    bus.req_a        = '0;
    bus.req_b        = '0;
    bus.req_rd       = '0;
    bus.resp_ready   = 1'b0;

    //            op     sa    sb    ds    a              b              expected       latency
    tbl[0]  = '{3'd5, 1'b0, 1'b0, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, NL};
    tbl[1]  = '{3'd6, 1'b0, 1'b0, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         CL};
    tbl[2]  = '{3'd5, 1'b0, 1'b0, 1'b0, 32'd7,         32'd2,         32'd3,         NL};
    tbl[3]  = '{3'd5, 1'b0, 1'b0, 1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    tbl[4]  = '{3'd6, 1'b0, 1'b0, 1'b0, 32'd5,         32'd0,         32'd5,         1};
    tbl[5]  = '{3'd5, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[6]  = '{3'd6, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    tbl[7]  = '{3'd3, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         NL};
    tbl[8]  = '{3'd4, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         NL};
    tbl[9]  = '{3'd4, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NL};
    tbl[10] = '{3'd4, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NL};
    tbl[11] = '{3'd4, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NL};
    tbl[12] = '{3'd5, 1'b0, 1'b0, 1'b1, 32'd100,       32'd7,         32'd14,        NL};
    tbl[13] = '{3'd6, 1'b0, 1'b0, 1'b1, 32'd100,       32'd7,         32'd2,         CL};
    tbl[14] = '{3'd6, 1'b0, 1'b0, 1'b1, 32'd100,       32'd8,         32'd4,         NL};
    tbl[15] = '{3'd0, 1'b0, 1'b0, 1'b0, 32'd5,         32'd6,         32'd0,         1};
    tbl[16] = '{3'd7, 1'b1, 1'b1, 1'b1, 32'd5,         32'd6,         32'd0,         1};
    tbl[17] = '{3'd3, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFA, NL};
    tbl[18] = '{3'd5, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, NL};
    tbl[19] = '{3'd5, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         NL};

    repeat (3) @(negedge clk);
    chk("rst.req_ready",   64'(bus.req_ready), 64'd1);
    chk("rst.busy",        64'(busy), 64'd0);
    chk("rst.resp_valid",  64'(bus.resp_valid), 64'd0);
    chk("rst.resp_result", 64'(bus.resp_result), 64'd0);
    chk("rst.resp_rd",     64'(bus.resp_rd), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++)
      run_op(tbl[i].op, tbl[i].sa, tbl[i].sb, tbl[i].ds, tbl[i].a, tbl[i].b, 5'(i + 1),
             tbl[i].exp, tbl[i].lat, $sformatf("vec%0d", i));

    // Backpressure: result held in DONE, and a pending request is not taken.
    issue(3'd3, 1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 5'd9);
    wait_resp(lat);
    chk("bp.lat", 64'(lat), 64'(NL));
    bus.req_op    = 3'd3;
    bus.req_a     = 32'd1;
    bus.req_b     = 32'd1;
    bus.req_rd    = 5'd1;
    bus.req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d.res", k),   64'(bus.resp_result), 64'd15);
      chk($sformatf("bp%0d.rd", k),    64'(bus.resp_rd), 64'd9);
      chk($sformatf("bp%0d.ready", k), 64'(bus.req_ready), 64'd0);
      chk($sformatf("bp%0d.valid", k), 64'(bus.resp_valid), 64'd1);
      @(negedge clk);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("bp.after.ready", 64'(bus.req_ready), 64'd1);
    chk("bp.after.valid", 64'(bus.resp_valid), 64'd0);

    // Flush in BUSY cycle 10.
    issue(3'd5, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd3, 5'd12);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flbusy.ready", 64'(bus.req_ready), 64'd1);
    chk("flbusy.busy",  64'(busy), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      seen |= bus.resp_valid;
      @(negedge clk);
    end
    chk("flbusy.novalid", 64'(seen), 64'd0);

    // Flush coincident with accept of a one-cycle special case.
    flush = 1'b1;
    issue(3'd5, 1'b0, 1'b0, 1'b0, 32'd9, 32'd0, 5'd13);
    flush = 1'b0;
    @(negedge clk);
    chk("flacc.ready", 64'(bus.req_ready), 64'd1);
    chk("flacc.valid", 64'(bus.resp_valid), 64'd0);
    chk("flacc.busy",  64'(busy), 64'd0);

    // Flush wins over resp_ready in DONE.
    issue(3'd3, 1'b0, 1'b0, 1'b0, 32'd6, 32'd7, 5'd14);
    wait_resp(lat);
    chk("fldone.res", 64'(bus.resp_result), 64'd42);
    flush          = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    flush          = 1'b0;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("fldone.valid", 64'(bus.resp_valid), 64'd0);
    chk("fldone.ready", 64'(bus.req_ready), 64'd1);

    // Asynchronous reset in BUSY cycle 10, then the cache must be empty.
    elat = ref_lat(3'd5, 1'b1, 32'd100, 32'd7);
    run_op(3'd5, 1'b0, 1'b0, 1'b1, 32'd100, 32'd7, 5'd3, 32'd14, elat, "prerst");
    issue(3'd4, 1'b0, 1'b0, 1'b0, $urandom, $urandom, 5'd17);
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rstmid.req_ready",   64'(bus.req_ready), 64'd1);
    chk("rstmid.busy",        64'(busy), 64'd0);
    chk("rstmid.resp_valid",  64'(bus.resp_valid), 64'd0);
    chk("rstmid.resp_result", 64'(bus.resp_result), 64'd0);
    chk("rstmid.resp_rd",     64'(bus.resp_rd), 64'd0);
    mc_v = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    elat = ref_lat(3'd5, 1'b1, 32'd100, 32'd7);
    run_op(3'd5, 1'b0, 1'b0, 1'b1, 32'd100, 32'd7, 5'd4, 32'd14, elat, "postrst");

    // Randomized ops against the reference model.
    pa  = 32'd100;
    pb  = 32'd7;
    pds = 1'b1;
    for (int n = 0; n < 60; n++) begin
      mode = $urandom_range(0, 9);
      if (mode < 2)      op = 3'd3;
      else if (mode < 4) op = 3'd4;
      else if (mode < 7) op = 3'd5;
      else if (mode < 9) op = 3'd6;
      else begin
        op = 3'($urandom_range(0, 3));
        if (op == 3'd3) op = 3'd7;
      end
      sa = 1'($urandom);
      sb = 1'($urandom);
      ds = 1'($urandom);
      a  = $urandom;
      b  = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0: b = 32'd0;
        1: begin a = SMIN; b = 32'hFFFF_FFFF; end
        2: begin a = pa; b = pb; ds = pds; end
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      exp  = ref_res(op, sa, sb, ds, a, b);
      elat = ref_lat(op, ds, a, b);
      run_op(op, sa, sb, ds, a, b, 5'($urandom), exp, elat, $sformatf("rnd%0d", n));
      pa  = a;
      pb  = b;
      pds = ds;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
